// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_PUSH
    } rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10,
        PAR_RSVD = 2'b11
    } par_t;

    localparam int DLEN_BASE = 5;
    localparam int DATA_W    = 8;
    localparam int ENTRY_W   = 10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with level output; a pop frees room for a push in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (level_q != '0);
        do_push  = push && ((level_q != FULL_LVL) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign level = level_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver: majority-voted bit FSM, error/break flags, FIFO and level interrupt.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK50MHZ,
    input  logic              n_rst,
    input  logic              Baud_tick,
    input  logic [1:0]        D_len,
    input  logic              S_num,
    input  logic [1:0]        Par,
    input  logic              RxD,
    input  logic              rx_enable,
    input  logic              n_RD,
    input  logic              C_nD,
    input  logic              Clr_EF,
    input  logic [CNT_W-1:0]  Rx_thresh,
    output logic              Rx_RDY,
    output logic [DATA_W-1:0] out_data,
    output logic              head_PE,
    output logic              head_FE,
    output logic [CNT_W-1:0]  rx_level,
    output logic              PE_Fg,
    output logic              FE_Fg,
    output logic              OE_Fg,
    output logic              BRK_Fg,
    output logic              n_INT
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    rx_state_t           state_q, state_d;
    logic                sync1_q, sync2_q, prev_q;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                s0_q, s0_d, s1_q, s1_d;
    logic                pe_q, pe_d, fe_q, fe_d;
    logic                par_bit_q, par_bit_d;
    logic [1:0]          dlen_q, dlen_d;
    logic                snum_q, snum_d;
    par_t                par_q, par_d;
    logic                pe_fg_q, pe_fg_d, fe_fg_q, fe_fg_d;
    logic                oe_fg_q, oe_fg_d, brk_fg_q, brk_fg_d;
    logic                n_int_q, n_int_d;

    logic                fall_edge, at_s0, at_s1, at_vote, at_end, vote;
    logic                last_bit, par_en, push, pop_req, brk_evt, oe_evt;
    logic                fifo_empty, fifo_full;
    logic [ENTRY_W-1:0]  head;

    assign fall_edge = prev_q & ~sync2_q;
    assign at_s0     = Baud_tick && (tick_q == TICK_S0);
    assign at_s1     = Baud_tick && (tick_q == TICK_S1);
    assign at_vote   = Baud_tick && (tick_q == TICK_VOTE);
    assign at_end    = Baud_tick && (tick_q == TICK_LAST);
    assign vote      = maj3(s0_q, s1_q, sync2_q);
    assign last_bit  = (bit_cnt_q == ({1'b0, dlen_q} + 3'(DLEN_BASE - 1)));
    assign par_en    = (par_q == PAR_ODD) || (par_q == PAR_EVEN);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        s0_d      = at_s0 ? sync2_q : s0_q;
        s1_d      = at_s1 ? sync2_q : s1_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        par_bit_d = par_bit_q;
        dlen_d    = dlen_q;
        snum_d    = snum_q;
        par_d     = par_q;

        if (Baud_tick) tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (rx_enable && fall_edge) begin
                    state_d   = ST_START;
                    tick_d    = '0;
                    bit_cnt_d = '0;
                    data_d    = '0;
                    pe_d      = 1'b0;
                    fe_d      = 1'b0;
                    par_bit_d = 1'b0;
                    dlen_d    = D_len;
                    snum_d    = S_num;
                    par_d     = par_t'(Par);
                end
            end
            ST_START: begin
                if (at_vote && vote) state_d = ST_IDLE;
                else if (at_end)     state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_vote) data_d[bit_cnt_q] = vote;
                if (at_end) begin
                    if (last_bit) state_d = par_en ? ST_PARITY : ST_STOP1;
                    else          bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (at_vote) begin
                    par_bit_d = vote;
                    pe_d      = (par_q == PAR_ODD) ? ~(^data_q ^ vote) : (^data_q ^ vote);
                end
                if (at_end) state_d = ST_STOP1;
            end
            // Stop bits finish at the vote tick so the next start edge is never missed.
            ST_STOP1: begin
                if (at_vote) begin
                    if (!vote) fe_d = 1'b1;
                    state_d = snum_q ? ST_STOP2 : ST_PUSH;
                end
            end
            ST_STOP2: begin
                if (at_vote) begin
                    if (!vote) fe_d = 1'b1;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (!rx_enable && (state_q != ST_PUSH)) state_d = ST_IDLE;
    end

    assign push    = (state_q == ST_PUSH);
    assign pop_req = ~n_RD & ~C_nD;
    assign brk_evt = push && (data_q == '0) && fe_q && (!par_en || !par_bit_q);
    assign oe_evt  = push && fifo_full && !pop_req;

    always_comb begin
        pe_fg_d  = Clr_EF ? 1'b0 : pe_fg_q;
        fe_fg_d  = Clr_EF ? 1'b0 : fe_fg_q;
        oe_fg_d  = Clr_EF ? 1'b0 : oe_fg_q;
        brk_fg_d = Clr_EF ? 1'b0 : brk_fg_q;
        if (push && pe_q) pe_fg_d  = 1'b1;
        if (push && fe_q) fe_fg_d  = 1'b1;
        if (oe_evt)       oe_fg_d  = 1'b1;
        if (brk_evt)      brk_fg_d = 1'b1;
        n_int_d = ~(pe_fg_q | fe_fg_q | oe_fg_q | brk_fg_q |
                    ((Rx_thresh != '0) && (rx_level >= Rx_thresh)));
    end

    always_ff @(posedge CLK50MHZ) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            par_bit_q <= 1'b0;
            dlen_q    <= 2'b11;
            snum_q    <= 1'b0;
            par_q     <= PAR_NONE;
            pe_fg_q   <= 1'b0;
            fe_fg_q   <= 1'b0;
            oe_fg_q   <= 1'b0;
            brk_fg_q  <= 1'b0;
            n_int_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sync1_q   <= RxD;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            par_bit_q <= par_bit_d;
            dlen_q    <= dlen_d;
            snum_q    <= snum_d;
            par_q     <= par_d;
            pe_fg_q   <= pe_fg_d;
            fe_fg_q   <= fe_fg_d;
            oe_fg_q   <= oe_fg_d;
            brk_fg_q  <= brk_fg_d;
            n_int_q   <= n_int_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (CLK50MHZ),
        .n_rst (n_rst),
        .push  (push),
        .pop   (pop_req),
        .wdata ({fe_q, pe_q, data_q}),
        .rdata (head),
        .level (rx_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign Rx_RDY   = ~fifo_empty;
    assign out_data = head[DATA_W-1:0];
    assign head_PE  = head[DATA_W];
    assign head_FE  = head[DATA_W+1];
    assign PE_Fg    = pe_fg_q;
    assign FE_Fg    = fe_fg_q;
    assign OE_Fg    = oe_fg_q;
    assign BRK_Fg   = brk_fg_q;
    assign n_INT    = n_int_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a 4-deep FIFO and 16x oversampling.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       n_rst, RxD, rx_enable, n_RD, C_nD, Clr_EF, S_num;
    logic [1:0] D_len, Par;
    logic [2:0] Rx_thresh;
    logic       Rx_RDY, head_PE, head_FE, PE_Fg, FE_Fg, OE_Fg, BRK_Fg, n_INT;
    logic [7:0] out_data;
    logic [2:0] rx_level;
    logic [1:0] div = 2'd0;
    logic       Baud_tick;
    int         checks = 0;
    int         errors = 0;

    always #10 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign Baud_tick = (div == 2'd3);

    uart_rx_ctrl #(.FIFO_DEPTH(4), .OVERSAMPLE(16), .CNT_W(3)) dut (
        .CLK50MHZ(clk), .n_rst(n_rst), .Baud_tick(Baud_tick), .D_len(D_len),
        .S_num(S_num), .Par(Par), .RxD(RxD), .rx_enable(rx_enable), .n_RD(n_RD),
        .C_nD(C_nD), .Clr_EF(Clr_EF), .Rx_thresh(Rx_thresh), .Rx_RDY(Rx_RDY),
        .out_data(out_data), .head_PE(head_PE), .head_FE(head_FE), .rx_level(rx_level),
        .PE_Fg(PE_Fg), .FE_Fg(FE_Fg), .OE_Fg(OE_Fg), .BRK_Fg(BRK_Fg), .n_INT(n_INT)
    );

    task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                              input logic par_bit, input int nstop);
        RxD = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            RxD = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (has_par) begin
            RxD = par_bit;
            repeat (BIT_CLKS) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            RxD = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic pop_one();
        n_RD = 1'b0;
        C_nD = 1'b0;
        @(negedge clk);
        n_RD = 1'b1;
    endtask

    task automatic clear_flags();
        Clr_EF = 1'b1;
        @(negedge clk);
        Clr_EF = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; RxD = 1'b1; rx_enable = 1'b1; n_RD = 1'b1; C_nD = 1'b0;
        Clr_EF = 1'b0; D_len = 2'b11; S_num = 1'b0; Par = 2'b00; Rx_thresh = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (Rx_RDY !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy got %0h exp 0", Rx_RDY); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %0h exp 0", out_data); end
        checks++; if ({head_PE, head_FE} !== 2'b00) begin errors++; $display("[TB] FAIL reset_head got %0b exp 00", {head_PE, head_FE}); end
        checks++; if (rx_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got %0d exp 0", rx_level); end
        checks++; if ({PE_Fg, FE_Fg, OE_Fg, BRK_Fg} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %0b exp 0000", {PE_Fg, FE_Fg, OE_Fg, BRK_Fg}); end
        checks++; if (n_INT !== 1'b1) begin errors++; $display("[TB] FAIL reset_nint got %0h exp 1", n_INT); end
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        send_frame(8'hA5, 8, 0, 1'b0, 1);
        checks++; if (Rx_RDY !== 1'b1) begin errors++; $display("[TB] FAIL 8n1_rdy got %0h exp 1", Rx_RDY); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("[TB] FAIL 8n1_data got %0h exp a5", out_data); end
        checks++; if ({head_PE, head_FE} !== 2'b00) begin errors++; $display("[TB] FAIL 8n1_head got %0b exp 00", {head_PE, head_FE}); end
        checks++; if ({PE_Fg, FE_Fg, OE_Fg, BRK_Fg, n_INT} !== 5'b00001) begin errors++; $display("[TB] FAIL 8n1_flags got %0b exp 00001", {PE_Fg, FE_Fg, OE_Fg, BRK_Fg, n_INT}); end
        n_RD = 1'b0; C_nD = 1'b1;
        @(negedge clk);
        n_RD = 1'b1; C_nD = 1'b0;
        checks++; if (rx_level !== 3'd1) begin errors++; $display("[TB] FAIL cfg_read_nopop got %0d exp 1", rx_level); end
        pop_one();
        checks++; if (Rx_RDY !== 1'b0) begin errors++; $display("[TB] FAIL 8n1_pop_rdy got %0h exp 0", Rx_RDY); end
        pop_one();
        checks++; if (rx_level !== 3'd0) begin errors++; $display("[TB] FAIL empty_pop_level got %0d exp 0", rx_level); end
    endtask

    task automatic test_char_formats();
        D_len = 2'b10; Par = 2'b10; S_num = 1'b1;
        send_frame(8'h55, 7, 1, 1'b1, 2);
        checks++; if (out_data !== 8'h55) begin errors++; $display("[TB] FAIL 7e2_data got %0h exp 55", out_data); end
        checks++; if ({head_FE, head_PE} !== 2'b01) begin errors++; $display("[TB] FAIL 7e2_head got %0b exp 01", {head_FE, head_PE}); end
        checks++; if (PE_Fg !== 1'b1) begin errors++; $display("[TB] FAIL 7e2_pefg got %0h exp 1", PE_Fg); end
        checks++; if (n_INT !== 1'b0) begin errors++; $display("[TB] FAIL 7e2_nint got %0h exp 0", n_INT); end
        pop_one();
        clear_flags();
        checks++; if (PE_Fg !== 1'b0) begin errors++; $display("[TB] FAIL clr_pefg got %0h exp 0", PE_Fg); end
        checks++; if (n_INT !== 1'b0) begin errors++; $display("[TB] FAIL clr_nint_lag got %0h exp 0", n_INT); end
        @(negedge clk);
        checks++; if (n_INT !== 1'b1) begin errors++; $display("[TB] FAIL clr_nint got %0h exp 1", n_INT); end
        D_len = 2'b01; Par = 2'b01; S_num = 1'b0;
        send_frame(8'h2B, 6, 1, 1'b1, 1);
        checks++; if ({head_PE, out_data} !== 9'h02B) begin errors++; $display("[TB] FAIL 6o1_entry got %0h exp 02b", {head_PE, out_data}); end
        checks++; if (PE_Fg !== 1'b0) begin errors++; $display("[TB] FAIL 6o1_pefg got %0h exp 0", PE_Fg); end
        pop_one();
        D_len = 2'b00; Par = 2'b00;
        send_frame(8'h16, 5, 0, 1'b0, 1);
        checks++; if (out_data !== 8'h16) begin errors++; $display("[TB] FAIL 5n1_data got %0h exp 16", out_data); end
        pop_one();
        D_len = 2'b11;
    endtask

    task automatic test_false_start();
        RxD = 1'b0;
        repeat (16) @(negedge clk);
        RxD = 1'b1;
        repeat (700) @(negedge clk);
        checks++; if ({Rx_RDY, rx_level} !== 4'b0000) begin errors++; $display("[TB] FAIL false_start got %0h exp 0", {Rx_RDY, rx_level}); end
        send_frame(8'h3C, 8, 0, 1'b0, 1);
        checks++; if (out_data !== 8'h3C) begin errors++; $display("[TB] FAIL after_false_data got %0h exp 3c", out_data); end
        pop_one();
    endtask

    task automatic test_overrun();
        bit found = 0;
        send_frame(8'h11, 8, 0, 1'b0, 1);
        send_frame(8'h22, 8, 0, 1'b0, 1);
        send_frame(8'h33, 8, 0, 1'b0, 1);
        send_frame(8'h44, 8, 0, 1'b0, 1);
        send_frame(8'h55, 8, 0, 1'b0, 1);
        checks++; if (rx_level !== 3'd4) begin errors++; $display("[TB] FAIL ovr_level got %0d exp 4", rx_level); end
        checks++; if (OE_Fg !== 1'b1) begin errors++; $display("[TB] FAIL ovr_oefg got %0h exp 1", OE_Fg); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("[TB] FAIL ovr_head got %0h exp 11", out_data); end
        clear_flags();
        @(negedge clk);
        checks++; if ({OE_Fg, n_INT} !== 2'b01) begin errors++; $display("[TB] FAIL ovr_clear got %0b exp 01", {OE_Fg, n_INT}); end
        fork
            send_frame(8'h66, 8, 0, 1'b0, 1);
            begin
                for (int i = 0; i < 1000 && !found; i++) begin
                    @(negedge clk);
                    if (dut.state_q == ST_PUSH) begin
                        pop_one();
                        found = 1;
                    end
                end
            end
        join
        checks++; if (!found) begin errors++; $display("[TB] FAIL ovr_push_wait got timeout exp push"); end
        checks++; if ({OE_Fg, rx_level} !== 4'b0100) begin errors++; $display("[TB] FAIL ovr_simul got %0h exp 4", {OE_Fg, rx_level}); end
        checks++; if (out_data !== 8'h22) begin errors++; $display("[TB] FAIL ovr_e2 got %0h exp 22", out_data); end
        pop_one();
        checks++; if (out_data !== 8'h33) begin errors++; $display("[TB] FAIL ovr_e3 got %0h exp 33", out_data); end
        pop_one();
        checks++; if (out_data !== 8'h44) begin errors++; $display("[TB] FAIL ovr_e4 got %0h exp 44", out_data); end
        pop_one();
        checks++; if (out_data !== 8'h66) begin errors++; $display("[TB] FAIL ovr_e5 got %0h exp 66", out_data); end
        pop_one();
        checks++; if (Rx_RDY !== 1'b0) begin errors++; $display("[TB] FAIL ovr_drain got %0h exp 0", Rx_RDY); end
    endtask

    task automatic test_break();
        RxD = 1'b0;
        repeat (2 * 10 * BIT_CLKS) @(negedge clk);
        RxD = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (rx_level !== 3'd1) begin errors++; $display("[TB] FAIL brk_level got %0d exp 1", rx_level); end
        checks++; if ({head_FE, head_PE, out_data} !== 10'h200) begin errors++; $display("[TB] FAIL brk_entry got %0h exp 200", {head_FE, head_PE, out_data}); end
        checks++; if ({BRK_Fg, FE_Fg, n_INT} !== 3'b110) begin errors++; $display("[TB] FAIL brk_flags got %0b exp 110", {BRK_Fg, FE_Fg, n_INT}); end
        pop_one();
        clear_flags();
        @(negedge clk);
    endtask

    task automatic test_threshold();
        bit found = 0;
        Rx_thresh = 3'd3;
        send_frame(8'h01, 8, 0, 1'b0, 1);
        send_frame(8'h02, 8, 0, 1'b0, 1);
        checks++; if ({rx_level, n_INT} !== 4'b0101) begin errors++; $display("[TB] FAIL thr_below got %0h exp 5", {rx_level, n_INT}); end
        fork
            send_frame(8'h03, 8, 0, 1'b0, 1);
            begin
                for (int i = 0; i < 1000 && !found; i++) begin
                    @(negedge clk);
                    if (rx_level == 3'd3) found = 1;
                end
                checks++; if (!found) begin errors++; $display("[TB] FAIL thr_wait got timeout exp level 3"); end
                checks++; if (n_INT !== 1'b1) begin errors++; $display("[TB] FAIL thr_lag got %0h exp 1", n_INT); end
                @(negedge clk);
                checks++; if (n_INT !== 1'b0) begin errors++; $display("[TB] FAIL thr_hit got %0h exp 0", n_INT); end
            end
        join
        Rx_thresh = 3'd0;
        repeat (3) pop_one();
        @(negedge clk);
    endtask

    task automatic test_abort();
        fork
            send_frame(8'h5A, 8, 0, 1'b0, 1);
            begin
                repeat (300) @(negedge clk);
                rx_enable = 1'b0;
            end
        join
        rx_enable = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if ({Rx_RDY, rx_level} !== 4'b0000) begin errors++; $display("[TB] FAIL disable_abort got %0h exp 0", {Rx_RDY, rx_level}); end
        send_frame(8'h5A, 8, 0, 1'b0, 1);
        Rx_thresh = 3'd1;
        repeat (3) @(negedge clk);
        checks++; if ({out_data, n_INT} !== 9'h0B4) begin errors++; $display("[TB] FAIL pre_reset got %0h exp b4", {out_data, n_INT}); end
        fork
            send_frame(8'hC3, 8, 0, 1'b0, 1);
            begin
                repeat (300) @(negedge clk);
                n_rst = 1'b0;
            end
        join
        n_rst = 1'b1;
        @(negedge clk);
        checks++; if ({Rx_RDY, rx_level, out_data} !== 12'h000) begin errors++; $display("[TB] FAIL rst_abort got %0h exp 0", {Rx_RDY, rx_level, out_data}); end
        checks++; if ({head_PE, head_FE, PE_Fg, FE_Fg, OE_Fg, BRK_Fg, n_INT} !== 7'b0000001) begin errors++; $display("[TB] FAIL rst_outputs got %0b exp 0000001", {head_PE, head_FE, PE_Fg, FE_Fg, OE_Fg, BRK_Fg, n_INT}); end
        Rx_thresh = 3'd0;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_char_formats();
        test_false_start();
        test_overrun();
        test_break();
        test_threshold();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised successor to the current receiver top. It contains an oversampling receive FSM and a depth-parametrised FIFO that stores per-character error status. It adds 5–8 bit character lengths, a mid-bit majority vote, break detection, and a programmable FIFO-level interrupt. It sits between the RxD pin and the CPU bus interface, in place of the fixed-width receiver top.

Parameters:
FIFO_DEPTH, 16, number of FIFO entries; power of 2, range 4..256
OVERSAMPLE, 16, Baud_tick pulses per bit; even, minimum 8
CNT_W, $clog2(FIFO_DEPTH)+1, width of the FIFO level count

Ports:
CLK50MHZ  in  1  system clock
n_rst  in  1  synchronous, active-low reset
Baud_tick  in  1  one-cycle pulse at OVERSAMPLE×baud
D_len  in  2  character length: 00=5, 01=6, 10=7, 11=8 bits
S_num  in  1  stop bits: 0=one, 1=two
Par  in  2  parity: 00 none, 01 odd, 10 even, 11 treated as none
RxD  in  1  asynchronous serial input
rx_enable  in  1  receiver enable
n_RD  in  1  active-low CPU read strobe
C_nD  in  1  0 = data access, 1 = configuration access
Clr_EF  in  1  one-cycle pulse; clears sticky flags
Rx_thresh  in  CNT_W  interrupt level threshold; 0 disables the level interrupt
Rx_RDY  out  1  FIFO not empty
out_data  out  8  head character, zero-extended above D_len bits
head_PE  out  1  parity error of the head character
head_FE  out  1  framing error of the head character
rx_level  out  CNT_W  number of FIFO entries
PE_Fg  out  1  sticky parity error flag
FE_Fg  out  1  sticky framing error flag
OE_Fg  out  1  sticky overrun flag
BRK_Fg  out  1  sticky break flag
n_INT  out  1  active-low interrupt

Behaviour:
- Reset: all state is synchronous to CLK50MHZ; n_rst=0 at a rising edge resets it.
  - FSM goes to IDLE; FIFO is emptied.
  - Rx_RDY=0, out_data=0, head_PE=0, head_FE=0, rx_level=0.
  - All sticky flags are 0; n_INT=1; synchroniser flops load 1.
- A reset mid-frame aborts the frame with no FIFO write.
- RxD passes through a 2-flop synchroniser; edge detection and sampling use the synchronised value only.
- Bit timing: a tick counter counts Baud_tick pulses from 0 to OVERSAMPLE-1 within each bit.
- Bit value is the majority of the samples at ticks M-1, M and M+1, where M=OVERSAMPLE/2-1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH.
  - IDLE: a falling edge with rx_enable=1 enters START and clears the tick counter.
  - START: if the voted value is 1, this is a false start; return to IDLE. Otherwise, at tick OVERSAMPLE-1, enter DATA.
  - DATA: shifts bits LSB first into bit positions 0..L-1, where L = D_len+5. After L bits, go to PARITY if parity is enabled, else STOP1.
  - PARITY: compares the sampled bit against the expected value. Odd: data XOR parity must be 1. Even: data XOR parity must be 0. A mismatch sets the frame's PE.
  - STOP1: a voted 0 sets the frame's FE. Then go to STOP2 if S_num=1, else PUSH.
  - STOP2: a voted 0 sets FE. Then go to PUSH.
  - PUSH: one clock cycle; pushes the frame, then returns to IDLE.
- Stop-bit exit timing: the FSM leaves STOP1/STOP2 at the sample tick M+1, not the bit end. This allows resynchronisation on back-to-back frames.
- rx_enable=0 in any state other than PUSH forces IDLE with no write.
- Break: data all zero AND FE=1 AND voted parity 0 (when parity is enabled) sets BRK_Fg. The character is still pushed.
- FIFO entry is {FE, PE, data[7:0]}. Output is show-ahead: out_data, head_PE and head_FE reflect the head entry whenever Rx_RDY=1.
- Pop occurs when n_RD=0 && C_nD=0 && Rx_RDY=1. Hold n_RD low for 1 cycle per pop; every low cycle pops.
- Pop while empty is ignored; the level stays 0.
- Push and pop in the same cycle: the level is unchanged.
  - This is allowed even when the FIFO is full; no overrun results.
- Push while full with no pop: the character is discarded and OE_Fg is set. FIFO contents are unchanged.
- Sticky flags: PE_Fg and FE_Fg are set by any pushed or discarded frame with that error.
- Clear priority: Clr_EF clears all four sticky flags. If a set event occurs in the same cycle, the set wins.
- Interrupt: n_INT = ~(PE_Fg | FE_Fg | OE_Fg | BRK_Fg | (Rx_thresh != 0 && rx_level >= Rx_thresh)).
  - n_INT is registered: 1 cycle after the cause.
- Pointer arithmetic is modulo FIFO_DEPTH; rx_level saturates at FIFO_DEPTH by construction.
- Configuration inputs (D_len, S_num, Par) are sampled in IDLE on the start edge and held for the frame.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum
  - par_t enum (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_RSVD)
  - constants DLEN_BASE=5, DATA_W=8, ENTRY_W=10
- One sub-module uart_rx_fifo:
  - parameters DEPTH and WIDTH
  - show-ahead output, level output
  - push/pop with simultaneous-access rule
- The FSM and flag logic stay in uart_rx_ctrl.

Test Plan:
- 8N1 frame 0xA5, OVERSAMPLE=16 → Rx_RDY=1 one cycle after PUSH; out_data=0xA5; flags 0; one pop gives Rx_RDY=0.
- 7E2 frame 0x55 with a wrong parity bit → head_PE=1, PE_Fg=1, n_INT=0. A Clr_EF pulse gives PE_Fg=0 and n_INT=1 the next cycle.
- RxD low pulse of 4 ticks in IDLE → false start; no push; FSM returns to IDLE.
- FIFO_DEPTH=4: send 5 frames with no reads → rx_level=4, OE_Fg=1, entries 1–4 intact. Then a read plus push in the same cycle → level 4 and no new OE event.
- RxD held low for 2 frame times, 8N1 → entry 0x00 with head_FE=1; BRK_Fg=1 and FE_Fg=1.
- Rx_thresh=3; push 3 frames → n_INT falls on the 3rd push plus 1 cycle. Drop rx_enable mid-frame, or n_rst=0 mid-frame → no push; after reset, all outputs are at their reset values.
